nco_sweep_ctrl: RTL and testbench
=================================

// Module: nco_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the vector-analyzer NCO. Steps the NCO phase increment
//  through cfg_num_pts points, waits for NCO pipeline flush plus analog settling, then
//  runs one req/done handshake per point with the downstream measurement accumulator.
//  Sits between the host register block and the NCO (drives its clken and phi_inc_i).
// PARAMETERS
//  APR       32  phase-accumulator / phase-increment width (matches NCO apr)
//  NPT_W     16  width of point count and point index
//  SETTLE_W  16  width of programmable settle count
//  NCO_LAT    8  cycles from phi_inc change to NCO output reflecting it (fixed flush wait)
// PORTS
//  clk            in   1         system clock
//  reset_n        in   1         async active-low reset
//  cfg_start_inc  in   APR       phase increment of point 0
//  cfg_step_inc   in   APR       increment added per point (two's-complement; negative = down-sweep)
//  cfg_num_pts    in   NPT_W     number of points in sweep
//  cfg_settle     in   SETTLE_W  extra settle cycles after NCO_LAT
//  start          in   1         1-cycle pulse: begin sweep (ignored unless IDLE)
//  abort          in   1         1-cycle pulse: terminate sweep
//  nco_out_valid  in   1         NCO out_valid
//  meas_done      in   1         accumulator finished current point
//  nco_clken      out  1         NCO clock enable
//  nco_phi_inc    out  APR       NCO phi_inc_i
//  meas_req       out  1         measurement request, level
//  point_idx      out  NPT_W     index of current point
//  busy           out  1         high in any state but IDLE
//  sweep_done     out  1         1-cycle pulse at normal sweep completion
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Everything registered; no comb input->output paths.
//  States: IDLE, SETTLE, MEAS, STEP, FINISH.
//  IDLE: on start, latch cfg_* (changes mid-sweep ignored); if cfg_num_pts==0 -> FINISH,
//   else nco_phi_inc<=cfg_start_inc, point_idx<=0, nco_clken<=1, load settle counter
//   with NCO_LAT+cfg_settle (width SETTLE_W+1, no overflow), -> SETTLE.
//  SETTLE: counter decrements each cycle; leave when counter==0 AND nco_out_valid==1
//   (waits indefinitely for out_valid); -> MEAS with meas_req<=1.
//   Settle length from nco_phi_inc update to meas_req rising = NCO_LAT+cfg_settle+1 cycles.
//  MEAS: meas_req held until meas_done sampled high; next cycle meas_req=0.
//   If point_idx==num_pts-1 -> FINISH, else -> STEP. meas_done outside MEAS ignored.
//  STEP: nco_phi_inc<=nco_phi_inc+step (mod 2^APR, wraps silently), point_idx+=1,
//   reload settle counter, -> SETTLE.
//  FINISH: sweep_done=1 for exactly one cycle, nco_clken<=0, busy<=0, -> IDLE.
//   nco_phi_inc and point_idx retain last values until next start.
//  abort: from any non-IDLE state, next cycle IDLE, meas_req=0, nco_clken=0, busy=0,
//   no sweep_done. abort beats start and meas_done in the same cycle; abort in IDLE no-op.
//  meas_done and abort same cycle in MEAS: abort wins, point not counted.
//  start while busy: ignored. reset_n mid-sweep: immediate return to reset values.
// STRUCTURE
//  Shared package nco_ctrl_pkg: state enum, NCO_LAT default, APR default (shared with NCO wrapper).
//  One sub-module: nco_settle_cnt (loadable down-counter, zero flag) for SETTLE.
//  FSM, increment adder and point counter in this module.
// TESTING
//  start_inc=0x0100_0000, step=0x0010_0000, num_pts=3, settle=4, meas_done 2 cyc after req
//   -> phi_inc 0x0100_0000/0x0110_0000/0x0120_0000, 3 req pulses, req rises 13 cyc after each
//   phi_inc update, single sweep_done after 3rd done.
//  num_pts=0 + start -> sweep_done 1 cycle later pulse, meas_req never high, busy 1 cycle.
//  start_inc=0xFFFF_FFF0, step=0x20, num_pts=2 -> second phi_inc=0x0000_0010 (wrap).
//  nco_out_valid held 0 for 50 cycles -> meas_req stays 0 until out_valid rises, then 1 cycle later.
//  abort asserted together with meas_done on point 1 of 4 -> IDLE next cycle, meas_req=0,
//   nco_clken=0, no sweep_done; new start then restarts at point_idx 0.
//  reset_n low during MEAS -> all outputs 0 asynchronously; start mid-sweep has no effect.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller and the NCO wrapper.
package nco_ctrl_pkg;

  localparam int APR_DEF     = 32;
  localparam int NCO_LAT_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_MEAS   = 3'd2,
    ST_STEP   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/nco_settle_cnt.sv
// Loadable down-counter that parks at zero. Load has priority over counting.
module nco_settle_cnt #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO phase increment, waits for flush plus
// settling, then performs one req/done measurement handshake per point.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int APR      = APR_DEF,
  parameter int NPT_W    = 16,
  parameter int SETTLE_W = 16,
  parameter int NCO_LAT  = NCO_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [APR-1:0]      cfg_start_inc,
  input  logic [APR-1:0]      cfg_step_inc,
  input  logic [NPT_W-1:0]    cfg_num_pts,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                start,
  input  logic                abort,
  input  logic                nco_out_valid,
  input  logic                meas_done,
  output logic                nco_clken,
  output logic [APR-1:0]      nco_phi_inc,
  output logic                meas_req,
  output logic [NPT_W-1:0]    point_idx,
  output logic                busy,
  output logic                sweep_done,
  output logic [2:0]          dbg_state
);

  state_t              r_state;
  logic [APR-1:0]      r_step;
  logic [NPT_W-1:0]    r_num_pts;
  logic [SETTLE_W-1:0] r_settle;

  logic [SETTLE_W-1:0] w_settle_src;
  logic [SETTLE_W:0]   w_load_val;
  logic                w_load;
  logic                w_cnt_zero;
  logic                w_last_pt;

  // Counter is (re)loaded on the same edge that updates nco_phi_inc, so the
  // settle window is measured from the increment change.
  assign w_settle_src = (r_state == ST_IDLE) ? cfg_settle : r_settle;
  assign w_load_val   = (SETTLE_W+1)'(NCO_LAT) + {1'b0, w_settle_src};
  assign w_load       = ((r_state == ST_IDLE) && start && !abort && (cfg_num_pts != '0)) ||
                        ((r_state == ST_STEP) && !abort);
  assign w_last_pt    = (point_idx == (r_num_pts - NPT_W'(1)));
  assign dbg_state    = r_state;

  nco_settle_cnt #(.W(SETTLE_W+1)) u_settle_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_cnt_zero)
  );

  // Handshake: meas_req is a level raised on entering MEAS and dropped on the
  // edge that samples meas_done high; meas_done is ignored in all other states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_num_pts   <= '0;
      r_settle    <= '0;
      nco_clken   <= 1'b0;
      nco_phi_inc <= '0;
      meas_req    <= 1'b0;
      point_idx   <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        meas_req  <= 1'b0;
        nco_clken <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_step    <= cfg_step_inc;
              r_num_pts <= cfg_num_pts;
              r_settle  <= cfg_settle;
              busy      <= 1'b1;
              if (cfg_num_pts == '0) begin
                sweep_done <= 1'b1;
                r_state    <= ST_FINISH;
              end else begin
                nco_phi_inc <= cfg_start_inc;
                point_idx   <= '0;
                nco_clken   <= 1'b1;
                r_state     <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (w_cnt_zero && nco_out_valid) begin
              meas_req <= 1'b1;
              r_state  <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (meas_done) begin
              meas_req <= 1'b0;
              if (w_last_pt) begin
                sweep_done <= 1'b1;
                r_state    <= ST_FINISH;
              end else begin
                r_state <= ST_STEP;
              end
            end
          end
          ST_STEP: begin
            nco_phi_inc <= nco_phi_inc + r_step;
            point_idx   <= point_idx + NPT_W'(1);
            r_state     <= ST_SETTLE;
          end
          ST_FINISH: begin
            nco_clken <= 1'b0;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: sweep timing, empty sweep, wrap, out_valid stall,
// abort with meas_done, start while busy and asynchronous reset.
module tb_nco_sweep_ctrl;
  import nco_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cfg_start_inc;
  logic [31:0] cfg_step_inc;
  logic [15:0] cfg_num_pts;
  logic [15:0] cfg_settle;
  logic        start;
  logic        abort;
  logic        nco_out_valid;
  logic        meas_done;
  logic        nco_clken;
  logic [31:0] nco_phi_inc;
  logic        meas_req;
  logic [15:0] point_idx;
  logic        busy;
  logic        sweep_done;
  logic [2:0]  dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int req_rise_cnt = 0;
  logic req_prev = 1'b0;

  nco_sweep_ctrl u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_start_inc (cfg_start_inc),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_num_pts   (cfg_num_pts),
    .cfg_settle    (cfg_settle),
    .start         (start),
    .abort         (abort),
    .nco_out_valid (nco_out_valid),
    .meas_done     (meas_done),
    .nco_clken     (nco_clken),
    .nco_phi_inc   (nco_phi_inc),
    .meas_req      (meas_req),
    .point_idx     (point_idx),
    .busy          (busy),
    .sweep_done    (sweep_done),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // pulse monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (sweep_done) done_cnt++;
    if (meas_req && !req_prev) req_rise_cnt++;
    req_prev = meas_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!meas_req && n < 200) begin
      tick();
      n++;
    end
  endtask

  // one point: check increment/index, settle latency, then done 2 cycles after req
  task automatic run_point(input string tag, input logic [31:0] exp_phi,
                           input logic [15:0] exp_idx, input int exp_lat, input bit last);
    int n;
    check({tag, "_phi"}, nco_phi_inc, exp_phi);
    check({tag, "_idx"}, point_idx, exp_idx);
    wait_req(n);
    check({tag, "_lat"}, n, exp_lat);
    tick();
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    check({tag, "_req_low"}, meas_req, 1'b0);
    check({tag, "_done"}, sweep_done, last);
    if (!last) tick();
  endtask

  initial begin
    int n;
    int done_snap;
    int req_any;
    reset_n = 1'b0;
    cfg_start_inc = 32'h0100_0000;
    cfg_step_inc  = 32'h0010_0000;
    cfg_num_pts   = 16'd3;
    cfg_settle    = 16'd4;
    start = 1'b0;
    abort = 1'b0;
    nco_out_valid = 1'b1;
    meas_done = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_clken", nco_clken, 1'b0);
    check("rst_phi", nco_phi_inc, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    tick();

    // 3-point up-sweep; config changes after start must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_step_inc = 32'hDEAD_0000;
    cfg_num_pts  = 16'd9;
    check("s1_busy", busy, 1'b1);
    check("s1_clken", nco_clken, 1'b1);
    check("s1_state", dbg_state, ST_SETTLE);
    run_point("s1_p0", 32'h0100_0000, 16'd0, 13, 1'b0);
    run_point("s1_p1", 32'h0110_0000, 16'd1, 13, 1'b0);
    run_point("s1_p2", 32'h0120_0000, 16'd2, 13, 1'b1);
    tick();
    check("s1_done_low", sweep_done, 1'b0);
    check("s1_idle_busy", busy, 1'b0);
    check("s1_idle_clken", nco_clken, 1'b0);
    check("s1_keep_phi", nco_phi_inc, 32'h0120_0000);
    check("s1_keep_idx", point_idx, 16'd2);
    check("s1_req_rises", req_rise_cnt, 3);
    check("s1_done_pulses", done_cnt, 1);

    // empty sweep
    cfg_num_pts = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("np0_done", sweep_done, 1'b1);
    check("np0_busy", busy, 1'b1);
    check("np0_clken", nco_clken, 1'b0);
    tick();
    check("np0_done_low", sweep_done, 1'b0);
    check("np0_busy_low", busy, 1'b0);
    check("np0_req_rises", req_rise_cnt, 3);
    check("np0_done_pulses", done_cnt, 2);

    // increment wrap, zero extra settle
    cfg_start_inc = 32'hFFFF_FFF0;
    cfg_step_inc  = 32'h0000_0020;
    cfg_num_pts   = 16'd2;
    cfg_settle    = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_point("wr_p0", 32'hFFFF_FFF0, 16'd0, 9, 1'b0);
    run_point("wr_p1", 32'h0000_0010, 16'd1, 9, 1'b1);
    tick();

    // out_valid stall
    cfg_start_inc = 32'h0000_1000;
    cfg_num_pts   = 16'd1;
    cfg_settle    = 16'd4;
    nco_out_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    req_any = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (meas_req) req_any = 1;
    end
    check("ov_req_held_low", req_any, 0);
    nco_out_valid = 1'b1;
    tick();
    check("ov_req_rise", meas_req, 1'b1);
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    check("ov_done", sweep_done, 1'b1);
    tick();

    // abort together with meas_done on point 1 of 4
    cfg_start_inc = 32'h0000_0200;
    cfg_step_inc  = 32'h0000_0040;
    cfg_num_pts   = 16'd4;
    cfg_settle    = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_point("ab_p0", 32'h0000_0200, 16'd0, 9, 1'b0);
    check("ab_p1_phi", nco_phi_inc, 32'h0000_0240);
    wait_req(n);
    check("ab_p1_lat", n, 9);
    done_snap = done_cnt;
    meas_done = 1'b1;
    abort = 1'b1;
    tick();
    meas_done = 1'b0;
    abort = 1'b0;
    check("ab_state", dbg_state, ST_IDLE);
    check("ab_req", meas_req, 1'b0);
    check("ab_clken", nco_clken, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_idx", point_idx, 16'd1);
    tick();
    tick();
    check("ab_no_done", done_cnt, done_snap);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_idx", point_idx, 16'd0);
    check("rs_phi", nco_phi_inc, 32'h0000_0200);
    check("rs_busy", busy, 1'b1);

    // start while busy is ignored
    tick();
    tick();
    cfg_start_inc = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sb_phi", nco_phi_inc, 32'h0000_0200);
    check("sb_state", dbg_state, ST_SETTLE);
    wait_req(n);
    check("sb_req", meas_req, 1'b1);

    // asynchronous reset during MEAS
    reset_n = 1'b0;
    #1;
    check("ar_req", meas_req, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_clken", nco_clken, 1'b0);
    check("ar_phi", nco_phi_inc, 32'h0);
    check("ar_idx", point_idx, 16'd0);
    check("ar_state", dbg_state, ST_IDLE);
    tick();
    reset_n = 1'b1;
    tick();
    check("ar_after_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
